// File: rtl/stable_matching_pkg.sv
// Shared helpers and FSM encoding for the sequential Gale-Shapley matcher.
package stable_matching_pkg;

  // ceil(log2(x)); returns 0 for x <= 1
  function automatic int sm_log2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sm_pow2_round(input int x);
    return 1 << sm_log2(x);
  endfunction

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } sm_state_e;

endpackage

// File: rtl/sm_rank_cmp.sv
// Decides whether receiver row prefers proposer s over its current partner s1:
// the first row entry equal to either one decides; no hit means not better.
module sm_rank_cmp #(
  parameter int Kr = 10,
  parameter int LS = 4
) (
  input  logic [Kr*LS-1:0] row,
  input  logic [LS-1:0]    s,
  input  logic [LS-1:0]    s1,
  output logic             better
);

  logic [Kr-1:0] eq_s;
  logic [Kr-1:0] eq_s1;

  for (genvar j = 0; j < Kr; j++) begin : g_eq
    assign eq_s[j]  = ~|(row[j*LS +: LS] ^ s);
    assign eq_s1[j] = ~|(row[j*LS +: LS] ^ s1);
  end

  logic seen;

  always_comb begin
    seen   = 1'b0;
    better = 1'b0;
    for (int j = 0; j < Kr; j++) begin
      if (!seen && (eq_s[j] || eq_s1[j])) begin
        better = eq_s[j];
        seen   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stable_matching_seq.sv
// Sequential Gale-Shapley engine: captures preferences on start, issues one
// proposal per clock, and reports the final receiver->proposer match list.
// Handshake: start is taken only in IDLE/DONE; busy covers LOAD and RUN, and
// done is a single-cycle pulse in FIN, after which results hold until next start.
module stable_matching_seq
  import stable_matching_pkg::*;
#(
  parameter int Kr = 10,
  parameter int Ks = 10,
  parameter int S  = 10,
  parameter int R  = 10,
  localparam int LS  = sm_log2(S),
  localparam int LR  = sm_log2(R),
  localparam int PCW = sm_log2(Ks + 1),
  localparam int CW  = sm_log2(S * Ks + 1),
  localparam int RW  = R * Kr * LS,
  localparam int GW  = RW + S * Ks * LR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [GW-1:0] g,
  output logic          busy,
  output logic          done,
  output logic [R*LS-1:0] o,
  output logic [R-1:0]  r_matched,
  output logic [CW-1:0] prop_cnt
);

  localparam logic [PCW-1:0] KS_P  = PCW'(Ks);
  localparam logic [LR:0]    R_LIM = (LR + 1)'(R);

  sm_state_e         state_q, state_d;
  logic [GW-1:0]     g_q;
  logic [PCW-1:0]    pc_q [S];
  logic [S-1:0]      s_is_match_q;
  logic [R-1:0]      r_matched_q;
  logic [LS-1:0]     o_q [R];
  logic [CW-1:0]     prop_cnt_q;

  logic [S-1:0]      cand;
  logic [S-1:0]      win_oh;
  logic              any_cand;
  logic [LS-1:0]     win;
  logic [PCW-1:0]    pref_idx;
  logic [LR-1:0]     r_sel;
  logic              r_ok;
  logic [LR-1:0]     r_idx;
  logic [Kr*LS-1:0]  r_row;
  logic [LS-1:0]     s1;
  logic              better;

  // Proposer selection: isolate lowest set candidate bit, then encode it.
  always_comb begin
    for (int i = 0; i < S; i++) begin
      cand[i] = (pc_q[i] != '0) && !s_is_match_q[i];
    end
  end

  assign win_oh   = cand & (~cand + S'(1));
  assign any_cand = |cand;

  always_comb begin
    win = '0;
    for (int i = 0; i < S; i++) begin
      if (win_oh[i]) win = win | LS'(i);
    end
  end

  always_comb begin
    pref_idx = KS_P - pc_q[win];
    r_sel    = g_q[RW + LR*Ks*int'(win) + LR*int'(pref_idx) +: LR];
    r_ok     = ({1'b0, r_sel} < R_LIM);
    r_idx    = r_ok ? r_sel : '0;
    r_row    = g_q[LS*Kr*int'(r_idx) +: Kr*LS];
    s1       = o_q[r_idx];
  end

  sm_rank_cmp #(.Kr(Kr), .LS(LS)) u_rank_cmp (
    .row    (r_row),
    .s      (win),
    .s1     (s1),
    .better (better)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       state_d = RUN;
      RUN:        if (!any_cand) state_d = FIN;
      FIN:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      g_q          <= '0;
      s_is_match_q <= '0;
      r_matched_q  <= '0;
      prop_cnt_q   <= '0;
      for (int i = 0; i < S; i++) pc_q[i] <= '0;
      for (int i = 0; i < R; i++) o_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            g_q          <= g;
            s_is_match_q <= '0;
            r_matched_q  <= '0;
            prop_cnt_q   <= '0;
            for (int i = 0; i < S; i++) pc_q[i] <= KS_P;
            for (int i = 0; i < R; i++) o_q[i] <= '0;
          end
        end
        RUN: begin
          if (any_cand) begin
            pc_q[win]  <= pc_q[win] - PCW'(1);
            prop_cnt_q <= prop_cnt_q + CW'(1);
            // Out-of-range receivers only consume the proposal.
            if (r_ok) begin
              if (!r_matched_q[r_idx]) begin
                o_q[r_idx]         <= win;
                r_matched_q[r_idx] <= 1'b1;
                s_is_match_q[win]  <= 1'b1;
              end else if (better) begin
                o_q[r_idx]        <= win;
                s_is_match_q[win] <= 1'b1;
                s_is_match_q[s1]  <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == LOAD) || (state_q == RUN);
  assign done      = (state_q == FIN);
  assign r_matched = r_matched_q;
  assign prop_cnt  = prop_cnt_q;

  for (genvar r = 0; r < R; r++) begin : g_out
    assign o[r*LS +: LS] = o_q[r];
  end

endmodule

// File: tb/tb_stable_matching_seq.sv
// Bench for stable_matching_seq: directed runs plus randomized preference sets
// scored against an integer-rank Gale-Shapley model.
module tb_stable_matching_seq;

  localparam int KR = 4;
  localparam int KS = 4;
  localparam int NS = 5;
  localparam int NR = 5;
  localparam int LS = 3;
  localparam int LR = 3;
  localparam int CW = 5;
  localparam int GW = NR*KR*LS + NS*KS*LR;
  localparam int OW = NR*LS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] g = '0;
  logic          busy;
  logic          done;
  logic [OW-1:0] o;
  logic [NR-1:0] r_matched;
  logic [CW-1:0] prop_cnt;

  int spref [NS][KS];
  int rpref [NR][KR];

  logic [OW-1:0] exp_q [$];
  logic [NR-1:0] exp_rm;
  int            exp_cnt;

  int passed = 0;
  int total  = 0;

  stable_matching_seq #(.Kr(KR), .Ks(KS), .S(NS), .R(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .g         (g),
    .busy      (busy),
    .done      (done),
    .o         (o),
    .r_matched (r_matched),
    .prop_cnt  (prop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int rank_of(input int r, input int s);
    for (int j = 0; j < KR; j++) if (rpref[r][j] == s) return j;
    return KR;
  endfunction

  // Reference: plain proposer-loop Gale-Shapley on integer preference tables.
  task automatic model();
    int nxt [NS];
    bit m [NS];
    int owner [NR];
    int s;
    int r;
    logic [OW-1:0] eo;
    for (int i = 0; i < NS; i++) begin nxt[i] = 0; m[i] = 1'b0; end
    for (int i = 0; i < NR; i++) owner[i] = -1;
    exp_cnt = 0;
    for (int it = 0; it <= NS*KS; it++) begin
      s = -1;
      for (int i = NS-1; i >= 0; i--) if (!m[i] && nxt[i] < KS) s = i;
      if (s < 0) break;
      r = spref[s][nxt[s]];
      nxt[s]++;
      exp_cnt++;
      if (r < NR) begin
        if (owner[r] < 0) begin
          owner[r] = s;
          m[s] = 1'b1;
        end else if (rank_of(r, s) < rank_of(r, owner[r])) begin
          m[owner[r]] = 1'b0;
          owner[r] = s;
          m[s] = 1'b1;
        end
      end
    end
    eo = '0;
    exp_rm = '0;
    for (int i = 0; i < NR; i++) begin
      if (owner[i] >= 0) begin
        eo[i*LS +: LS] = LS'(owner[i]);
        exp_rm[i] = 1'b1;
      end
    end
    exp_q.push_back(eo);
  endtask

  task automatic fill_random(input int maxv);
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < KS; j++) spref[i][j] = $urandom_range(0, maxv);
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < KR; j++) rpref[i][j] = $urandom_range(0, maxv);
  endtask

  task automatic pack_g();
    int v;
    g = '0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < KR; j++) begin
        v = rpref[i][j];
        g[LS*KR*i + LS*j +: LS] = v[LS-1:0];
      end
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < KS; j++) begin
        v = spref[i][j];
        g[NR*KR*LS + LR*KS*i + LR*j +: LR] = v[LR-1:0];
      end
  endtask

  task automatic start_run();
    pack_g();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Waits for done (bounded), optionally pulsing start with junk g mid-run.
  task automatic wait_check(input string tag, input int poke_at);
    int busy_cyc;
    int k;
    logic [OW-1:0] eo;
    chk({tag, " busy_after_start"}, busy, 1'b1);
    busy_cyc = 1;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == poke_at) begin
        g = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!done && busy) busy_cyc++;
    end
    start = 1'b0;
    eo = exp_q.pop_front();
    chk({tag, " done_seen"}, done, 1'b1);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    chk({tag, " busy_cycles"}, busy_cyc, exp_cnt + 2);
    chk({tag, " prop_cnt"}, prop_cnt, exp_cnt);
    chk({tag, " o"}, o, eo);
    chk({tag, " r_matched"}, r_matched, exp_rm);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " o_hold"}, o, eo);
  endtask

  task automatic full_run(input string tag);
    model();
    start_run();
    wait_check(tag, -1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst o", o, '0);
    chk("rst r_matched", r_matched, '0);
    chk("rst prop_cnt", prop_cnt, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity preferences: each proposer's first choice accepts immediately.
    fill_random(NR - 1);
    for (int i = 0; i < NS; i++) spref[i][0] = i;
    for (int i = 0; i < NR; i++) rpref[i][0] = i;
    full_run("identity");
    chk("identity cnt_const", prop_cnt, 5);
    chk("identity o_const", o, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});

    // start during RUN must be ignored, result from original capture.
    fill_random(NR - 1);
    model();
    start_run();
    wait_check("midstart", 2);

    // Asynchronous reset during RUN.
    fill_random(7);
    start_run();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort o", o, '0);
    chk("abort r_matched", r_matched, '0);
    chk("abort prop_cnt", prop_cnt, '0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    full_run("post_reset");

    // Back-to-back randomized runs, each started from DONE.
    for (int n = 0; n < 10; n++) begin
      fill_random((n % 2 == 0) ? NR - 1 : 7);
      full_run($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
